// File: rtl/reg_read_stage.sv
// rtl/reg_read_stage.sv - register-read stage with physical register file, writeback bypass and skid buffer
module reg_read_stage #(
  parameter int PHYS_REGS  = 64,
  parameter int XLEN       = 32,
  parameter int RS_ENTRIES = 16,
  parameter int WB_PORTS   = 2,
  parameter int PAYLOAD_W  = 64,
  localparam int PRW       = $clog2(PHYS_REGS),
  localparam int RSW       = $clog2(RS_ENTRIES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      iss_valid,
  output logic                      iss_ready,
  input  logic [RSW-1:0]            iss_rs_idx,
  input  logic [PRW-1:0]            iss_prs1,
  input  logic [PRW-1:0]            iss_prs2,
  input  logic [PAYLOAD_W-1:0]      iss_payload,
  input  logic [WB_PORTS-1:0]       wb_valid,
  input  logic [WB_PORTS*PRW-1:0]   wb_preg,
  input  logic [WB_PORTS*XLEN-1:0]  wb_data,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [XLEN-1:0]           ex_op1,
  output logic [XLEN-1:0]           ex_op2,
  output logic [PAYLOAD_W-1:0]      ex_payload,
  output logic                      rs_free_valid,
  output logic [RSW-1:0]            rs_free_idx
);

  // Physical register file; preg 0 is never written so it always holds zero.
  logic [XLEN-1:0] rf_q [PHYS_REGS];
  logic [XLEN-1:0] rf_d [PHYS_REGS];

  // Output register, skid entry and scheduler-facing handshake state.
  logic                 ex_valid_q,      ex_valid_d;
  logic [XLEN-1:0]      ex_op1_q,        ex_op1_d;
  logic [XLEN-1:0]      ex_op2_q,        ex_op2_d;
  logic [PAYLOAD_W-1:0] ex_payload_q,    ex_payload_d;
  logic                 skid_valid_q,    skid_valid_d;
  logic [XLEN-1:0]      skid_op1_q,      skid_op1_d;
  logic [XLEN-1:0]      skid_op2_q,      skid_op2_d;
  logic [PAYLOAD_W-1:0] skid_payload_q,  skid_payload_d;
  logic                 iss_ready_q,     iss_ready_d;
  logic                 rs_free_valid_q, rs_free_valid_d;
  logic [RSW-1:0]       rs_free_idx_q,   rs_free_idx_d;

  logic [XLEN-1:0] op1_rd;
  logic [XLEN-1:0] op2_rd;
  logic            accept;
  logic            out_free;

  // Register file update: ports applied in ascending order so the highest port wins a collision.
  always_comb begin
    for (int i = 0; i < PHYS_REGS; i++) begin
      rf_d[i] = rf_q[i];
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p] && (wb_preg[p*PRW +: PRW] != '0)) begin
        rf_d[wb_preg[p*PRW +: PRW]] = wb_data[p*XLEN +: XLEN];
      end
    end
  end

  // Operand read with same-cycle writeback bypass; highest matching port wins, preg 0 forced to zero.
  always_comb begin
    op1_rd = rf_q[iss_prs1];
    op2_rd = rf_q[iss_prs2];
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p] && (wb_preg[p*PRW +: PRW] == iss_prs1)) begin
        op1_rd = wb_data[p*XLEN +: XLEN];
      end
      if (wb_valid[p] && (wb_preg[p*PRW +: PRW] == iss_prs2)) begin
        op2_rd = wb_data[p*XLEN +: XLEN];
      end
    end
    if (iss_prs1 == '0) begin
      op1_rd = '0;
    end
    if (iss_prs2 == '0) begin
      op2_rd = '0;
    end
  end

  // Pipeline control: accept into output reg or skid, drain skid in order, flush empties both.
  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_op1_d        = ex_op1_q;
    ex_op2_d        = ex_op2_q;
    ex_payload_d    = ex_payload_q;
    skid_valid_d    = skid_valid_q;
    skid_op1_d      = skid_op1_q;
    skid_op2_d      = skid_op2_q;
    skid_payload_d  = skid_payload_q;
    rs_free_valid_d = 1'b0;
    rs_free_idx_d   = rs_free_idx_q;

    // iss_ready_q is low whenever the skid holds a uop, so accept and drain never coincide.
    accept   = iss_valid && iss_ready_q && !flush;
    out_free = !ex_valid_q || ex_ready;

    if (flush) begin
      ex_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (ex_valid_q && ex_ready) begin
        ex_valid_d = 1'b0;
      end
      if (skid_valid_q && ex_valid_q && ex_ready) begin
        ex_valid_d   = 1'b1;
        ex_op1_d     = skid_op1_q;
        ex_op2_d     = skid_op2_q;
        ex_payload_d = skid_payload_q;
        skid_valid_d = 1'b0;
      end
      if (accept) begin
        if (out_free) begin
          ex_valid_d   = 1'b1;
          ex_op1_d     = op1_rd;
          ex_op2_d     = op2_rd;
          ex_payload_d = iss_payload;
        end else begin
          skid_valid_d   = 1'b1;
          skid_op1_d     = op1_rd;
          skid_op2_d     = op2_rd;
          skid_payload_d = iss_payload;
        end
        rs_free_valid_d = 1'b1;
        rs_free_idx_d   = iss_rs_idx;
      end
    end

    iss_ready_d = !skid_valid_d;
  end

  // State registers; reset clears the register file and discards any held or skidded uop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        rf_q[i] <= '0;
      end
      ex_valid_q      <= 1'b0;
      ex_op1_q        <= '0;
      ex_op2_q        <= '0;
      ex_payload_q    <= '0;
      skid_valid_q    <= 1'b0;
      skid_op1_q      <= '0;
      skid_op2_q      <= '0;
      skid_payload_q  <= '0;
      iss_ready_q     <= 1'b1;
      rs_free_valid_q <= 1'b0;
      rs_free_idx_q   <= '0;
    end else begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        rf_q[i] <= rf_d[i];
      end
      ex_valid_q      <= ex_valid_d;
      ex_op1_q        <= ex_op1_d;
      ex_op2_q        <= ex_op2_d;
      ex_payload_q    <= ex_payload_d;
      skid_valid_q    <= skid_valid_d;
      skid_op1_q      <= skid_op1_d;
      skid_op2_q      <= skid_op2_d;
      skid_payload_q  <= skid_payload_d;
      iss_ready_q     <= iss_ready_d;
      rs_free_valid_q <= rs_free_valid_d;
      rs_free_idx_q   <= rs_free_idx_d;
    end
  end

  assign iss_ready     = iss_ready_q;
  assign ex_valid      = ex_valid_q;
  assign ex_op1        = ex_op1_q;
  assign ex_op2        = ex_op2_q;
  assign ex_payload    = ex_payload_q;
  assign rs_free_valid = rs_free_valid_q;
  assign rs_free_idx   = rs_free_idx_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// tb/tb_reg_read_stage.sv - randomized and directed bench for reg_read_stage against a queue model
module tb_reg_read_stage;
  localparam int PRW = 6;
  localparam int RSW = 4;
  localparam int XL  = 32;
  localparam int PW  = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              iss_valid = 1'b0;
  logic              iss_ready;
  logic [RSW-1:0]    iss_rs_idx = '0;
  logic [PRW-1:0]    iss_prs1 = '0;
  logic [PRW-1:0]    iss_prs2 = '0;
  logic [PW-1:0]     iss_payload = '0;
  logic [1:0]        wb_valid = '0;
  logic [2*PRW-1:0]  wb_preg = '0;
  logic [2*XL-1:0]   wb_data = '0;
  logic              ex_valid;
  logic              ex_ready = 1'b1;
  logic [XL-1:0]     ex_op1;
  logic [XL-1:0]     ex_op2;
  logic [PW-1:0]     ex_payload;
  logic              rs_free_valid;
  logic [RSW-1:0]    rs_free_idx;

  reg_read_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rs_idx(iss_rs_idx),
    .iss_prs1(iss_prs1), .iss_prs2(iss_prs2), .iss_payload(iss_payload),
    .wb_valid(wb_valid), .wb_preg(wb_preg), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_payload(ex_payload), .rs_free_valid(rs_free_valid), .rs_free_idx(rs_free_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural model: the stage is a FIFO of at most two uops, head visible to execute.
  typedef struct {
    logic [XL-1:0] op1;
    logic [XL-1:0] op2;
    logic [PW-1:0] pl;
  } uop_t;

  uop_t           mq[$];
  logic [XL-1:0]  mrf [64];
  logic           m_pulse = 1'b0;
  logic [RSW-1:0] m_idx = '0;

  function automatic logic [XL-1:0] mread(input logic [PRW-1:0] prs);
    logic [XL-1:0] v;
    if (prs == 0) return '0;
    v = mrf[prs];
    for (int p = 0; p < 2; p++)
      if (wb_valid[p] && wb_preg[p*PRW +: PRW] == prs) v = wb_data[p*XL +: XL];
    return v;
  endfunction

  always @(posedge clk) begin : model
    uop_t u;
    bit   acc;
    if (rst) begin
      mq.delete();
      foreach (mrf[i]) mrf[i] = '0;
      m_pulse = 1'b0;
      m_idx   = '0;
    end else begin
      acc = iss_valid && (mq.size() < 2) && !flush;
      u.op1 = mread(iss_prs1);
      u.op2 = mread(iss_prs2);
      u.pl  = iss_payload;
      if (flush) begin
        mq.delete();
        m_pulse = 1'b0;
      end else begin
        if (mq.size() > 0 && ex_ready) void'(mq.pop_front());
        if (acc) begin
          mq.push_back(u);
          m_idx = iss_rs_idx;
        end
        m_pulse = acc;
      end
      for (int p = 0; p < 2; p++)
        if (wb_valid[p] && wb_preg[p*PRW +: PRW] != 0)
          mrf[wb_preg[p*PRW +: PRW]] = wb_data[p*XL +: XL];
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("ex_valid", 64'(ex_valid), 64'(mq.size() > 0));
      check("iss_ready", 64'(iss_ready), 64'(mq.size() < 2));
      check("rs_free_valid", 64'(rs_free_valid), 64'(m_pulse));
      check("rs_free_idx", 64'(rs_free_idx), 64'(m_idx));
      if (mq.size() > 0) begin
        check("ex_op1", 64'(ex_op1), 64'(mq[0].op1));
        check("ex_op2", 64'(ex_op2), 64'(mq[0].op2));
        check("ex_payload", ex_payload, mq[0].pl);
      end
    end
  end

  int dut_xfers = 0;
  int dut_pulses = 0;
  always @(posedge clk) if (cmp_en && !rst && ex_valid && ex_ready) dut_xfers++;
  always @(negedge clk) if (cmp_en && rs_free_valid) dut_pulses++;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    iss_valid = 1'b0;
    wb_valid  = '0;
    flush     = 1'b0;
  endtask

  task automatic issue(input logic [RSW-1:0] idx, input logic [PRW-1:0] p1,
                       input logic [PRW-1:0] p2, input logic [PW-1:0] pl);
    iss_valid   = 1'b1;
    iss_rs_idx  = idx;
    iss_prs1    = p1;
    iss_prs2    = p2;
    iss_payload = pl;
  endtask

  task automatic wb(input int port, input logic [PRW-1:0] preg, input logic [XL-1:0] data);
    wb_valid[port]          = 1'b1;
    wb_preg[port*PRW +: PRW] = preg;
    wb_data[port*XL +: XL]   = data;
  endtask

  int x0, p0;
  bit ready_dropped;

  initial begin
    @(negedge clk);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    check("reset_ex_valid", 64'(ex_valid), 64'd0);
    check("reset_iss_ready", 64'(iss_ready), 64'd1);
    check("reset_rs_free_valid", 64'(rs_free_valid), 64'd0);
    check("reset_rs_free_idx", 64'(rs_free_idx), 64'd0);
    check("reset_ex_op1", 64'(ex_op1), 64'd0);
    check("reset_ex_payload", ex_payload, 64'd0);

    // Basic read with preg 0 source.
    wb(0, 6'd5, 32'hA5); tick(); idle();
    issue(4'd3, 6'd5, 6'd0, 64'h1); tick(); idle();
    check("t1_ex_valid", 64'(ex_valid), 64'd1);
    check("t1_op1", 64'(ex_op1), 64'hA5);
    check("t1_op2", 64'(ex_op2), 64'h0);
    check("t1_rs_free", 64'({rs_free_valid, rs_free_idx}), 64'h13);
    tick();
    check("t1_pulse_single", 64'(rs_free_valid), 64'd0);

    // Same-cycle bypass, then write collision.
    issue(4'd4, 6'd7, 6'd5, 64'h2); wb(0, 6'd7, 32'h11); tick(); idle();
    check("t2_bypass_op1", 64'(ex_op1), 64'h11);
    check("t2_op2", 64'(ex_op2), 64'hA5);
    wb(0, 6'd7, 32'h1); wb(1, 6'd7, 32'h2); tick(); idle();
    issue(4'd5, 6'd7, 6'd7, 64'h3); tick(); idle();
    check("t2_collision", 64'(ex_op1), 64'h2);

    // preg 0 stays zero, including under same-cycle writeback.
    issue(4'd1, 6'd0, 6'd0, 64'h4); wb(0, 6'd0, 32'hFF); tick(); idle();
    check("t4_p0_bypass", 64'({ex_op1, ex_op2}), 64'h0);
    issue(4'd1, 6'd0, 6'd0, 64'h5); tick(); idle(); tick();
    check("t4_p0_read", 64'(ex_op1), 64'h0);

    // Stall: A held on output, B in skid, drain in order.
    ex_ready = 1'b0;
    issue(4'd6, 6'd5, 6'd0, 64'hA); tick();
    issue(4'd7, 6'd7, 6'd0, 64'hB); tick(); idle();
    check("t3_skid_idx", 64'(rs_free_idx), 64'h7);
    check("t3_iss_ready_low", 64'(iss_ready), 64'd0);
    tick();
    check("t3_hold_op1", 64'(ex_op1), 64'hA5);
    check("t3_hold_payload", ex_payload, 64'hA);
    ex_ready = 1'b1; tick();
    check("t3_drain_b", 64'({ex_valid, ex_op1}), 64'h1_00000002);
    check("t3_iss_ready_back", 64'(iss_ready), 64'd1);
    tick();
    check("t3_empty", 64'(ex_valid), 64'd0);

    // Flush with both slots full and an issue offered.
    ex_ready = 1'b0;
    issue(4'd8, 6'd5, 6'd5, 64'hC); tick();
    issue(4'd9, 6'd5, 6'd5, 64'hD); tick();
    issue(4'd10, 6'd5, 6'd5, 64'hE); flush = 1'b1; tick(); idle();
    check("t5_ex_valid", 64'(ex_valid), 64'd0);
    check("t5_iss_ready", 64'(iss_ready), 64'd1);
    check("t5_no_pulse", 64'(rs_free_valid), 64'd0);
    ex_ready = 1'b1; tick();

    // 100 back-to-back issues.
    x0 = dut_xfers; p0 = dut_pulses; ready_dropped = 1'b0;
    for (int i = 0; i < 100; i++) begin
      issue(4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
            64'(1000 + i));
      tick();
      if (!iss_ready) ready_dropped = 1'b1;
    end
    idle(); tick(); tick();
    check("t6_xfers", 64'(dut_xfers - x0), 64'd100);
    check("t6_pulses", 64'(dut_pulses - p0), 64'd100);
    check("t6_ready_never_dropped", 64'(ready_dropped), 64'd0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      iss_valid   = ($urandom_range(0, 3) != 0);
      iss_rs_idx  = 4'($urandom);
      iss_prs1    = 6'($urandom_range(0, 7));
      iss_prs2    = 6'($urandom_range(0, 7));
      iss_payload = {32'(i), 32'($urandom)};
      wb_valid    = 2'($urandom);
      wb_preg     = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      wb_data     = {32'($urandom), 32'($urandom)};
      ex_ready    = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 40) == 0);
      rst         = ($urandom_range(0, 300) == 0);
      tick();
    end
    rst = 1'b0; idle(); ex_ready = 1'b1; tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
